// File: rtl/inst_mem_loader.sv
// inst_mem_loader: boot-time writer for the instruction memory.
//
// Receives a program image as a byte stream and writes it into instruction
// memory one 32-bit word at a time, keeping the CPU held until the whole
// image has arrived and its XOR checksum matches.
//
// Stream: N (16-bit LE word count), N words (4 bytes each, LE), then one
// checksum byte equal to the XOR of every preceding byte.
//
// Ports:
//   clk, rst       system clock, synchronous active-high reset
//   start          pulse; begins a load from IDLE, DONE or ERR
//   in_valid/in_data/in_ready   byte-stream handshake
//   mem_we/mem_addr/mem_wdata   instruction memory write port
//   cpu_hold       high keeps the CPU stalled; low only after a good load
//   load_done      level; image loaded and checksum good
//   load_err       level; oversize length or checksum mismatch
//   words_written  words written during the current load
module inst_mem_loader #(
    parameter int unsigned MEM_WORDS = 256,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        cpu_hold,
    output logic        load_done,
    output logic        load_err,
    output logic [15:0] words_written
);

    typedef enum logic [2:0] {
        StIdle,
        StHdrLo,
        StHdrHi,
        StData,
        StWrite,
        StChk,
        StDone,
        StErr
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] n_q, n_d;          // word count from the header
    logic [15:0] count_q, count_d;  // words written so far
    logic [31:0] word_q, word_d;    // word being assembled
    logic [1:0]  idx_q, idx_d;      // byte index within the word
    logic [7:0]  xor_q, xor_d;      // running XOR of accepted bytes

    logic        xfer;
    logic        can_start;
    logic [15:0] hdr_n;

    assign xfer      = in_valid && in_ready;
    assign can_start = (state_q == StIdle) || (state_q == StDone) || (state_q == StErr);
    assign hdr_n     = {in_data, n_q[7:0]};

    // State register and datapath flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            n_q     <= 16'd0;
            count_q <= 16'd0;
            word_q  <= 32'd0;
            idx_q   <= 2'd0;
            xor_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            count_q <= count_d;
            word_q  <= word_d;
            idx_q   <= idx_d;
            xor_q   <= xor_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle, StDone, StErr: begin
                if (start) state_d = StHdrLo;
            end
            StHdrLo: begin
                if (xfer) state_d = StHdrHi;
            end
            StHdrHi: begin
                if (xfer) begin
                    if ({16'd0, hdr_n} > MEM_WORDS) state_d = StErr;
                    else if (hdr_n == 16'd0)       state_d = StChk;
                    else                           state_d = StData;
                end
            end
            StData: begin
                if (xfer && (idx_q == 2'd3)) state_d = StWrite;
            end
            StWrite: begin
                state_d = ((count_q + 16'd1) == n_q) ? StChk : StData;
            end
            StChk: begin
                if (xfer) state_d = (in_data == xor_q) ? StDone : StErr;
            end
            default: state_d = StIdle;
        endcase
    end

    // Datapath next-state.
    always_comb begin
        n_d     = n_q;
        count_d = count_q;
        word_d  = word_q;
        idx_d   = idx_q;
        xor_d   = xor_q;

        if (can_start && start) begin
            count_d = 16'd0;
            xor_d   = 8'd0;
            idx_d   = 2'd0;
        end

        // The checksum byte itself never enters the running XOR.
        if (xfer && (state_q != StChk)) xor_d = xor_q ^ in_data;

        if (xfer && (state_q == StHdrLo)) n_d[7:0]  = in_data;
        if (xfer && (state_q == StHdrHi)) n_d[15:8] = in_data;

        // Shift in from the top so the first byte ends up in bits [7:0].
        if (xfer && (state_q == StData)) begin
            word_d = {in_data, word_q[31:8]};
            idx_d  = idx_q + 2'd1;
        end

        if (state_q == StWrite) count_d = count_q + 16'd1;
    end

    // Outputs.
    always_comb begin
        in_ready      = (state_q == StHdrLo) || (state_q == StHdrHi) ||
                        (state_q == StData)  || (state_q == StChk);
        mem_we        = (state_q == StWrite);
        mem_addr      = BASE_ADDR + {14'd0, count_q, 2'b00};
        mem_wdata     = word_q;
        cpu_hold      = (state_q != StDone);
        load_done     = (state_q == StDone);
        load_err      = (state_q == StErr);
        words_written = count_q;
    end

endmodule

// File: tb/tb_inst_mem_loader.sv
// Self-checking bench for inst_mem_loader: randomized image loads, expected
// writes queued by a stream-level model and popped by a write monitor.
module tb_inst_mem_loader;

    localparam int unsigned MEM_WORDS = 256;
    localparam logic [31:0] BASE      = 32'h0000_0100;

    logic        clk;
    logic        rst;
    logic        start;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_hold;
    logic        load_done;
    logic        load_err;
    logic [15:0] words_written;

    inst_mem_loader #(
        .MEM_WORDS(MEM_WORDS),
        .BASE_ADDR(BASE)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .cpu_hold     (cpu_hold),
        .load_done    (load_done),
        .load_err     (load_err),
        .words_written(words_written)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    logic [63:0] exp_q[$];   // {addr, data} of expected writes, in order
    int          writes_seen = 0;
    logic [31:0] wbuf[$];    // words of the next image

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    endtask

    // Write monitor: every mem_we cycle must match the head of the queue.
    always @(negedge clk) begin
        logic [63:0] e;
        if (!rst && mem_we) begin
            writes_seen++;
            check("in_ready_low_in_write", {31'd0, in_ready}, 32'd0);
            check("write_expected", {31'd0, exp_q.size() != 0}, 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("write_addr", mem_addr, e[63:32]);
                check("write_data", mem_wdata, e[31:0]);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Offer one byte after gmin..gmax idle cycles; hold it until accepted.
    task automatic send_byte(input logic [7:0] b, input int gmin, input int gmax);
        int w;
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        repeat ($urandom_range(gmin, gmax)) tick();
        in_valid = 1'b1;
        in_data  = b;
        w = 0;
        while (!in_ready && w <= 50) begin
            tick();
            w++;
        end
        check("byte_accepted", {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        in_data  = 8'($urandom);
    endtask

    // Full load of wbuf with header count n; mid_word >= 0 pulses start
    // just after the first byte of that word.
    task automatic run_load(input logic [15:0] n, input bit bad, input int gmin, input int gmax,
                            input int mid_word);
        logic [7:0] bytes[$];
        logic [7:0] x;
        logic [31:0] w;
        bit oversize;
        int t0;
        int n_exp;
        oversize = int'(n) > MEM_WORDS;
        bytes.push_back(n[7:0]);
        bytes.push_back(n[15:8]);
        n_exp = 0;
        if (!oversize) begin
            for (int k = 0; k < int'(n); k++) begin
                w = wbuf[k];
                for (int j = 0; j < 4; j++) bytes.push_back(w[8*j +: 8]);
                exp_q.push_back({BASE + 32'(4 * k), w});
            end
            n_exp = int'(n);
            x = 8'd0;
            foreach (bytes[i]) x = x ^ bytes[i];
            bytes.push_back(bad ? (x ^ 8'h01) : x);
        end
        writes_seen = 0;
        pulse_start();
        t0 = cyc;
        check("start_cpu_hold", {31'd0, cpu_hold}, 32'd1);
        check("start_done_clr", {31'd0, load_done}, 32'd0);
        check("start_err_clr", {31'd0, load_err}, 32'd0);
        check("start_count_clr", {16'd0, words_written}, 32'd0);
        foreach (bytes[i]) begin
            if (mid_word >= 0 && i == 3 + 4 * mid_word) begin
                in_valid = 1'b0;
                start    = 1'b1;
                tick();
                start    = 1'b0;
            end
            send_byte(bytes[i], gmin, gmax);
        end
        // One cycle after the last accepted byte.
        check("load_done", {31'd0, load_done}, {31'd0, !oversize && !bad});
        check("load_err", {31'd0, load_err}, {31'd0, oversize || bad});
        check("cpu_hold", {31'd0, cpu_hold}, {31'd0, oversize || bad});
        check("words_written", {16'd0, words_written}, 32'(n_exp));
        check("in_ready_after", {31'd0, in_ready}, 32'd0);
        if (gmax == 0 && mid_word < 0 && !oversize)
            check("load_cycles", 32'(cyc - t0), 32'(3 + 5 * int'(n)));
        repeat (3) tick();
        check("writes_seen", 32'(writes_seen), 32'(n_exp));
        check("pending_writes", 32'(exp_q.size()), 32'd0);
        check("status_held", {30'd0, load_done, load_err}, {30'd0, !oversize && !bad, oversize || bad});
        exp_q.delete();
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd0);
        check({tag, "_mem_we"}, {31'd0, mem_we}, 32'd0);
        check({tag, "_mem_addr"}, mem_addr, BASE);
        check({tag, "_mem_wdata"}, mem_wdata, 32'd0);
        check({tag, "_cpu_hold"}, {31'd0, cpu_hold}, 32'd1);
        check({tag, "_load_done"}, {31'd0, load_done}, 32'd0);
        check({tag, "_load_err"}, {31'd0, load_err}, 32'd0);
        check({tag, "_words"}, {16'd0, words_written}, 32'd0);
    endtask

    initial begin
        logic [15:0] n;
        rst      = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'd0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check_reset_values("reset");

        // Nominal two-word image, continuous valid.
        wbuf = '{32'h0000_0013, 32'h0010_0093};
        run_load(16'd2, 1'b0, 0, 0, -1);

        // Same image with a corrupted checksum.
        run_load(16'd2, 1'b1, 0, 0, -1);

        // Oversize header: error straight after the second header byte.
        wbuf.delete();
        run_load(16'd257, 1'b0, 0, 0, -1);

        // Zero-length image with valid toggling.
        run_load(16'd0, 1'b0, 1, 1, -1);

        // Reset after two bytes of the first word: nothing written.
        writes_seen = 0;
        pulse_start();
        send_byte(8'h01, 0, 0);
        send_byte(8'h00, 0, 0);
        send_byte(8'hAA, 0, 0);
        send_byte(8'hBB, 0, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset_values("midrst");
        repeat (8) tick();
        check("midrst_no_write", 32'(writes_seen), 32'd0);

        // Start pulsed during DATA is ignored.
        wbuf.delete();
        repeat (3) wbuf.push_back($urandom);
        run_load(16'd3, 1'b0, 0, 0, 1);

        // Reload after a good load.
        wbuf = '{32'hDEAD_BEEF};
        run_load(16'd1, 1'b0, 0, 0, -1);

        // Largest accepted image.
        wbuf.delete();
        for (int k = 0; k < int'(MEM_WORDS); k++) wbuf.push_back($urandom);
        run_load(16'(MEM_WORDS), 1'b0, 0, 0, -1);

        // Randomized loads.
        for (int r = 0; r < 8; r++) begin
            n = 16'($urandom_range(1, 6));
            wbuf.delete();
            for (int k = 0; k < int'(n); k++) wbuf.push_back($urandom);
            run_load(n, ($urandom_range(0, 3) == 0), 0, 2, -1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
